// File: rtl/roll_judge.sv
// rtl/roll_judge.sv - settle detector, guess judge and saturating counters for the LFSR dice generator
// Watches the displayed roll until it holds steady, latches it, and scores one guess per roll.
module roll_judge #(
   parameter int SETTLE_CYCLES = 134217728
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_roll_start,
   input  logic [3:0] i_random,
   input  logic [3:0] i_memory,
   input  logic [3:0] i_guess,
   input  logic       i_guess_valid,
   output logic       o_settled,
   output logic [3:0] o_value,
   output logic       o_repeat,
   output logic       o_result_valid,
   output logic       o_hit,
   output logic [7:0] o_score,
   output logic [7:0] o_rolls
);

   localparam int CW = $clog2(SETTLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ROLL, S_WAIT, S_RESULT} state_t;

   state_t        state, state_d;
   logic [3:0]    sample, sample_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          settled_d, repeat_d, result_valid_d, hit_d;
   logic [3:0]    value_d;
   logic [7:0]    score_d, rolls_d;
   logic          hit_now;

   assign hit_now = (i_guess == o_value);

   always_comb begin
      state_d        = state;
      sample_d       = sample;
      cnt_d          = cnt;
      settled_d      = o_settled;
      value_d        = o_value;
      repeat_d       = o_repeat;
      result_valid_d = 1'b0;
      hit_d          = o_hit;
      score_d        = o_score;
      rolls_d        = o_rolls;
      case (state)
         S_IDLE: begin
            if (i_roll_start) begin
               state_d  = S_ROLL;
               sample_d = i_random;
               cnt_d    = '0;
            end
         end
         S_ROLL: begin
            // Any movement of the displayed value restarts the stability window.
            if (i_roll_start || (i_random != sample)) begin
               sample_d = i_random;
               cnt_d    = '0;
            end else if (cnt == CNT_MAX) begin
               state_d   = S_WAIT;
               settled_d = 1'b1;
               value_d   = sample;
               repeat_d  = (sample == i_memory);
               rolls_d   = (o_rolls == 8'hFF) ? o_rolls : o_rolls + 8'd1;
            end else begin
               cnt_d = cnt + CW'(1);
            end
         end
         S_WAIT, S_RESULT: begin
            // A new roll forfeits any pending guess, including one in the same cycle.
            if (i_roll_start) begin
               state_d   = S_ROLL;
               sample_d  = i_random;
               cnt_d     = '0;
               settled_d = 1'b0;
               hit_d     = 1'b0;
               repeat_d  = 1'b0;
            end else if ((state == S_WAIT) && i_guess_valid) begin
               state_d        = S_RESULT;
               hit_d          = hit_now;
               result_valid_d = 1'b1;
               score_d        = (hit_now && (o_score != 8'hFF)) ? o_score + 8'd1 : o_score;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= S_IDLE;
         sample         <= '0;
         cnt            <= '0;
         o_settled      <= 1'b0;
         o_value        <= '0;
         o_repeat       <= 1'b0;
         o_result_valid <= 1'b0;
         o_hit          <= 1'b0;
         o_score        <= '0;
         o_rolls        <= '0;
      end else begin
         state          <= state_d;
         sample         <= sample_d;
         cnt            <= cnt_d;
         o_settled      <= settled_d;
         o_value        <= value_d;
         o_repeat       <= repeat_d;
         o_result_valid <= result_valid_d;
         o_hit          <= hit_d;
         o_score        <= score_d;
         o_rolls        <= rolls_d;
      end
   end

endmodule

// File: tb/tb_roll_judge.sv
// tb/tb_roll_judge.sv - directed vector bench for roll_judge with SETTLE_CYCLES=4
// Each table row is one clock edge: inputs applied before it, outputs checked after it.
module tb_roll_judge;

   logic       clk = 1'b0;
   logic       rst, roll_start, guess_valid;
   logic [3:0] rnd, mem, guess;
   logic       settled, repeat_f, result_valid, hit;
   logic [3:0] value;
   logic [7:0] score, rolls;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        start;
      logic [3:0]  rnd;
      logic [3:0]  mem;
      logic [3:0]  guess;
      logic        gv;
      logic [23:0] exp;
   } vec_t;

   vec_t vecs[$];

   roll_judge #(.SETTLE_CYCLES(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_roll_start(roll_start), .i_random(rnd),
      .i_memory(mem), .i_guess(guess), .i_guess_valid(guess_valid),
      .o_settled(settled), .o_value(value), .o_repeat(repeat_f),
      .o_result_valid(result_valid), .o_hit(hit), .o_score(score), .o_rolls(rolls)
   );

   always #5 clk = ~clk;

   wire [23:0] act = {settled, value, repeat_f, result_valid, hit, score, rolls};

   function automatic logic [23:0] mk(input logic s, input logic [3:0] v, input logic rp,
                                      input logic rv, input logic h, input logic [7:0] sc,
                                      input logic [7:0] rl);
      return {s, v, rp, rv, h, sc, rl};
   endfunction

   task automatic add(input logic r, input logic st, input logic [3:0] rn, input logic [3:0] m,
                      input logic [3:0] g, input logic gv, input logic [23:0] e);
      vec_t v;
      v.rst = r; v.start = st; v.rnd = rn; v.mem = m; v.guess = g; v.gv = gv; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic r, input logic st, input logic [3:0] rn, input logic [3:0] m,
                        input logic [3:0] g, input logic gv);
      rst = r; roll_start = st; rnd = rn; mem = m; guess = g; guess_valid = gv;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [23:0] a, input logic [23:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got set=%b val=%0d rep=%b rv=%b hit=%b score=%0d rolls=%0d, want set=%b val=%0d rep=%b rv=%b hit=%b score=%0d rolls=%0d",
                  name, a[23], a[22:19], a[18], a[17], a[16], a[15:8], a[7:0],
                  e[23], e[22:19], e[18], e[17], e[16], e[15:8], e[7:0]);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, a, e);
      end
   endtask

   initial begin
      string nm;
      logic [3:0] r;
      logic [7:0] e8;

      // reset, basic settle on 7, hit, ignored second guess
      add(1, 0, 7, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      add(0, 1, 7, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      repeat (3) add(0, 0, 7, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      add(0, 0, 7, 0, 0, 0, mk(1, 7, 0, 0, 0, 0, 1));
      add(0, 0, 7, 0, 7, 1, mk(1, 7, 0, 1, 1, 1, 1));
      add(0, 0, 7, 0, 0, 0, mk(1, 7, 0, 0, 1, 1, 1));
      add(0, 0, 7, 0, 7, 1, mk(1, 7, 0, 0, 1, 1, 1));
      // repeat roll on 9, hit
      add(0, 1, 9, 9, 0, 0, mk(0, 7, 0, 0, 0, 1, 1));
      repeat (3) add(0, 0, 9, 9, 0, 0, mk(0, 7, 0, 0, 0, 1, 1));
      add(0, 0, 9, 9, 0, 0, mk(1, 9, 1, 0, 0, 1, 2));
      add(0, 0, 9, 9, 9, 1, mk(1, 9, 1, 1, 1, 2, 2));
      // roll on 2, miss with guess 4
      add(0, 1, 2, 9, 0, 0, mk(0, 9, 0, 0, 0, 2, 2));
      repeat (3) add(0, 0, 2, 9, 0, 0, mk(0, 9, 0, 0, 0, 2, 2));
      add(0, 0, 2, 9, 0, 0, mk(1, 2, 0, 0, 0, 2, 3));
      add(0, 0, 2, 9, 4, 1, mk(1, 2, 0, 1, 0, 2, 3));
      add(0, 0, 2, 9, 0, 0, mk(1, 2, 0, 0, 0, 2, 3));
      // roll on 3, then start and guess together while waiting
      add(0, 1, 3, 9, 0, 0, mk(0, 2, 0, 0, 0, 2, 3));
      repeat (3) add(0, 0, 3, 9, 0, 0, mk(0, 2, 0, 0, 0, 2, 3));
      add(0, 0, 3, 9, 0, 0, mk(1, 3, 0, 0, 0, 2, 4));
      add(0, 1, 3, 9, 3, 1, mk(0, 3, 0, 0, 0, 2, 4));
      repeat (3) add(0, 0, 3, 9, 0, 0, mk(0, 3, 0, 0, 0, 2, 4));
      add(0, 0, 3, 9, 0, 0, mk(1, 3, 0, 0, 0, 2, 5));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].start, vecs[i].rnd, vecs[i].mem, vecs[i].guess, vecs[i].gv);
         nm = $sformatf("vec%0d", i);
         chk(nm, act, vecs[i].exp);
      end

      // unstable input: 3<->5 every 3 cycles, then hold 5; last change at step 20
      for (int i = 0; i <= 24; i++) begin
         r = (i >= 20) ? 4'd5 : (((i / 3) % 2) != 0 ? 4'd5 : 4'd3);
         drive(0, (i == 0), r, 9, 0, 0);
         if (i < 24) chk8($sformatf("unstable_settled%0d", i), {7'd0, settled}, 8'd0);
      end
      chk("unstable_final", act, mk(1, 5, 0, 0, 0, 2, 6));

      // reset in S_ROLL with cnt=2
      drive(0, 1, 6, 0, 0, 0);
      drive(0, 0, 6, 0, 0, 0);
      drive(0, 0, 6, 0, 0, 0);
      drive(1, 0, 6, 0, 0, 0);
      chk("rst_roll", act, mk(0, 0, 0, 0, 0, 0, 0));
      drive(0, 0, 6, 0, 0, 1);
      chk("rst_roll_guess", act, mk(0, 0, 0, 0, 0, 0, 0));

      // reset in S_RESULT
      drive(0, 1, 4, 0, 0, 0);
      repeat (4) drive(0, 0, 4, 0, 0, 0);
      chk("rst_settle", act, mk(1, 4, 0, 0, 0, 0, 1));
      drive(0, 0, 4, 0, 4, 1);
      chk("rst_hit", act, mk(1, 4, 0, 1, 1, 1, 1));
      drive(1, 0, 4, 0, 0, 0);
      chk("rst_result", act, mk(0, 0, 0, 0, 0, 0, 0));
      drive(0, 0, 4, 0, 0, 1);
      chk("rst_result_guess", act, mk(0, 0, 0, 0, 0, 0, 0));

      // saturation: 257 settle+hit rounds from a clean reset
      drive(1, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 257; k++) begin
         e8 = (k > 255) ? 8'd255 : 8'(k);
         drive(0, 1, 1, 0, 0, 0);
         repeat (4) drive(0, 0, 1, 0, 0, 0);
         chk8($sformatf("sat_rolls%0d", k), rolls, e8);
         drive(0, 0, 1, 0, 1, 1);
         chk8($sformatf("sat_score%0d", k), score, e8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
